uart_frame_scheduler: RTL and testbench

//  Shares the single UART transmitter between periodic own-tank position frames and

---
 rtl/uart_frame_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
//   Shares one UART transmitter between periodic own-tank position frames and
//   asynchronous event frames (fire / hit). Frames never interleave; a pending
//   event frame always wins over a pending position frame.
//
// Parameters
//   PERIOD        clk cycles between position-frame requests (>= 16)
//   BUSY_TIMEOUT  cycles to wait for i_tx_busy to rise before resending a byte
//
// Ports
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_select_mode    1 = game running, 0 = menu (no new frames, pending cleared)
//   i_xpos_tank      own tank X (10 bit)
//   i_ypos_tank      own tank Y (10 bit)
//   i_direction_tank own tank direction (0 up, 1 down, 2 left, 3 right)
//   i_fire_req       one-cycle pulse: shot fired
//   i_hit_req        one-cycle pulse: own tank hit
//   i_tx_busy        uart_tx busy flag
//   o_tx_start       one-cycle start pulse, o_tx_data valid in the same cycle
//   o_tx_data        byte to transmit
//   o_sched_busy     high while a frame is in progress
//
// Configuration macro
//   SCHED_CHECKSUM_EN  defined: POS frame 4 bytes (XOR checksum), EVT frame 2 bytes
//                      (complement). Undefined: POS 3 bytes, EVT 1 byte.
module uart_frame_scheduler #(
    parameter int unsigned PERIOD       = 1000000,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_select_mode,
    input  logic [9:0] i_xpos_tank,
    input  logic [9:0] i_ypos_tank,
    input  logic [1:0] i_direction_tank,
    input  logic       i_fire_req,
    input  logic       i_hit_req,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_sched_busy
);

`ifdef SCHED_CHECKSUM_EN
    localparam int unsigned POS_LEN = 4;
    localparam int unsigned EVT_LEN = 2;
`else
    localparam int unsigned POS_LEN = 3;
    localparam int unsigned EVT_LEN = 1;
`endif
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned TW      = $clog2(PERIOD);
    localparam int unsigned IW      = $clog2(POS_LEN);
    localparam int unsigned CW      = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StWaitHi, StWaitLo} state_e;

    state_e        r_state, w_state_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic          r_pos_pend, w_pos_pend_next;
    logic          r_fire_pend, w_fire_pend_next;
    logic          r_hit_pend, w_hit_pend_next;
    logic [7:0]    r_frame [MAX_LEN];
    logic [7:0]    w_frame_next [MAX_LEN];
    logic [IW-1:0] r_idx, w_idx_next;
    logic [IW-1:0] r_last, w_last_next;
    logic [CW-1:0] r_to_cnt, w_to_cnt_next;
    logic          r_tx_start, w_tx_start_next;
    logic [7:0]    r_tx_data, w_tx_data_next;

    logic [7:0]    w_evt_b0;
    logic [7:0]    w_pos_b0;

    assign w_evt_b0 = {2'b10, 4'b0000, r_hit_pend, r_fire_pend};
    assign w_pos_b0 = {2'b01, i_direction_tank, i_xpos_tank[9:8], i_ypos_tank[9:8]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_timer     <= '0;
            r_pos_pend  <= 1'b0;
            r_fire_pend <= 1'b0;
            r_hit_pend  <= 1'b0;
            r_frame     <= '{default: 8'h00};
            r_idx       <= '0;
            r_last      <= '0;
            r_to_cnt    <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_pos_pend  <= w_pos_pend_next;
            r_fire_pend <= w_fire_pend_next;
            r_hit_pend  <= w_hit_pend_next;
            r_frame     <= w_frame_next;
            r_idx       <= w_idx_next;
            r_last      <= w_last_next;
            r_to_cnt    <= w_to_cnt_next;
            r_tx_start  <= w_tx_start_next;
            r_tx_data   <= w_tx_data_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_timer_next     = r_timer;
        w_pos_pend_next  = r_pos_pend;
        w_fire_pend_next = r_fire_pend;
        w_hit_pend_next  = r_hit_pend;
        w_frame_next     = r_frame;
        w_idx_next       = r_idx;
        w_last_next      = r_last;
        w_to_cnt_next    = r_to_cnt;
        w_tx_start_next  = 1'b0;
        w_tx_data_next   = r_tx_data;

        unique case (r_state)
            StIdle: begin
                if (i_select_mode && (r_fire_pend || r_hit_pend)) begin
                    w_frame_next[0] = w_evt_b0;
`ifdef SCHED_CHECKSUM_EN
                    w_frame_next[1] = ~w_evt_b0;
`endif
                    w_last_next      = IW'(EVT_LEN - 1);
                    w_idx_next       = '0;
                    w_fire_pend_next = 1'b0;
                    w_hit_pend_next  = 1'b0;
                    w_state_next     = StSend;
                end else if (i_select_mode && r_pos_pend) begin
                    // Position is snapshotted here; later moves do not affect this frame.
                    w_frame_next[0] = w_pos_b0;
                    w_frame_next[1] = i_xpos_tank[7:0];
                    w_frame_next[2] = i_ypos_tank[7:0];
`ifdef SCHED_CHECKSUM_EN
                    w_frame_next[3] = w_pos_b0 ^ i_xpos_tank[7:0] ^ i_ypos_tank[7:0];
`endif
                    w_last_next     = IW'(POS_LEN - 1);
                    w_idx_next      = '0;
                    w_pos_pend_next = 1'b0;
                    w_state_next    = StSend;
                end
            end
            StSend: begin
                if (!i_tx_busy) begin
                    w_tx_start_next = 1'b1;
                    w_tx_data_next  = r_frame[r_idx];
                    w_to_cnt_next   = '0;
                    w_state_next    = StWaitHi;
                end
            end
            StWaitHi: begin
                if (i_tx_busy) begin
                    w_state_next = StWaitLo;
                end else if (r_to_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: resend the same byte.
                    w_state_next = StSend;
                end else begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end
            StWaitLo: begin
                if (!i_tx_busy) begin
                    if (r_idx == r_last) begin
                        w_state_next = StIdle;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                        w_state_next = StSend;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase

        // Requests set after the capture clear, so a pulse in the capture cycle stays pending.
        if (i_fire_req) w_fire_pend_next = 1'b1;
        if (i_hit_req)  w_hit_pend_next  = 1'b1;

        if (i_select_mode) begin
            if (r_timer == TW'(PERIOD - 1)) begin
                w_timer_next    = '0;
                w_pos_pend_next = 1'b1;
            end else begin
                w_timer_next = r_timer + 1'b1;
            end
        end else begin
            w_timer_next     = '0;
            w_pos_pend_next  = 1'b0;
            w_fire_pend_next = 1'b0;
            w_hit_pend_next  = 1'b0;
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_sched_busy = (r_state != StIdle);

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler
//   Drives uart_frame_scheduler (PERIOD=100) against a simple uart_tx model
//   (busy rises one cycle after tx_start, stays high 20 cycles) and compares the
//   transmitted byte stream and frame start times with frames built from the
//   frame format rules. Honours SCHED_CHECKSUM_EN the same way as the design.
module tb_uart_frame_scheduler;

    localparam int unsigned PERIOD       = 100;
    localparam int unsigned BUSY_TIMEOUT = 64;
    localparam int unsigned BUSY_LEN     = 20;
`ifdef SCHED_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       select_mode = 1'b1;
    logic [9:0] xpos = '0;
    logic [9:0] ypos = '0;
    logic [1:0] dir = '0;
    logic       fire_req = 1'b0;
    logic       hit_req = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       sched_busy;

    always #5 clk = ~clk;

    uart_frame_scheduler #(
        .PERIOD       (PERIOD),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_select_mode    (select_mode),
        .i_xpos_tank      (xpos),
        .i_ypos_tank      (ypos),
        .i_direction_tank (dir),
        .i_fire_req       (fire_req),
        .i_hit_req        (hit_req),
        .i_tx_busy        (tx_busy),
        .o_tx_start       (tx_start),
        .o_tx_data        (tx_data),
        .o_sched_busy     (sched_busy)
    );

    int unsigned cyc = 0;
    int unsigned base = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // uart_tx model
    int unsigned busy_cnt = 0;
    bit          uart_dead = 1'b0;
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (tx_start && !uart_dead) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Observed and expected byte streams
    logic [7:0]  obs_q[$];
    int unsigned obs_cyc[$];
    logic [7:0]  exp_q[$];

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            obs_q.push_back(tx_data);
            obs_cyc.push_back(cyc);
            check("start_while_busy", 32'(tx_busy), 32'd0);
        end
    end

    function automatic void push_pos(input int unsigned x, input int unsigned y,
                                     input int unsigned d);
        int unsigned b0;
        b0 = 64 + d * 16 + (x / 256) * 4 + (y / 256);
        exp_q.push_back(8'(b0));
        exp_q.push_back(8'(x % 256));
        exp_q.push_back(8'(y % 256));
        if (CSUM) exp_q.push_back(8'(b0 ^ (x % 256) ^ (y % 256)));
    endfunction

    function automatic void push_evt(input int unsigned hit, input int unsigned fire);
        int unsigned b0;
        b0 = 128 + 2 * hit + fire;
        exp_q.push_back(8'(b0));
        if (CSUM) exp_q.push_back(8'(255 - b0));
    endfunction

    task automatic wait_rel(input int unsigned rel);
        while (cyc - base < rel) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        fire_req = 1'b0;
        hit_req  = 1'b0;
        @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_sched_busy", 32'(sched_busy), 32'd0);
        @(negedge clk);
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        rst  = 1'b0;
        base = cyc;
    endtask

    // Checks that the n-th observed tx_start (1-based) happened at edge rel after reset.
    task automatic expect_start(input int unsigned n, input int unsigned rel, input string tag);
        while (obs_q.size() < n && (cyc - base) < rel + 8) @(negedge clk);
        if (obs_q.size() >= n) check(tag, obs_cyc[n-1] - base, rel);
        else check({tag, "_timeout"}, obs_q.size(), n);
    endtask

    task automatic pulse(input int unsigned rel, input logic f, input logic h);
        wait_rel(rel - 1);
        fire_req = f;
        hit_req  = h;
        @(negedge clk);
        fire_req = 1'b0;
        hit_req  = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic randomize_pos();
        xpos = 10'($urandom_range(0, 1023));
        ypos = 10'($urandom_range(0, 1023));
        dir  = 2'($urandom_range(0, 3));
    endtask

    // Optional event at edge t, then mid-frame pulses, then a position frame.
    task automatic run_evt(input string tag, input int unsigned ev, input int unsigned t,
                           input int unsigned nmid, input int unsigned mid_kind);
        int unsigned s_rel;
        int unsigned mask;
        int unsigned mt;
        int unsigned px, py, pd;
        select_mode = 1'b1;
        uart_dead   = 1'b0;
        randomize_pos();
        px = xpos; py = ypos; pd = dir;
        do_reset();
        mask = 0;
        if (ev != 0) begin
            push_evt(ev / 2, ev % 2);
            pulse(t, ev[0], ev[1]);
            expect_start(1, t + 2, {tag, "_evt_latency"});
            if (obs_cyc.size() > 0 && nmid > 0) begin
                s_rel = obs_cyc[0] - base;
                for (int j = 0; j < int'(nmid); j++) begin
                    mt = (mid_kind != 0) ? mid_kind : $urandom_range(1, 3);
                    mask = mask | mt;
                    pulse(s_rel + 2 + 4 * j + $urandom_range(0, 3), mt[0], mt[1]);
                end
                push_evt(mask / 2, mask % 2);
            end
        end else begin
            expect_start(1, PERIOD + 2, {tag, "_pos_latency"});
        end
        push_pos(px, py, pd);
        wait_rel(150);
        randomize_pos();
        wait_rel(180);
        select_mode = 1'b0;
        if ($urandom_range(0, 1) == 1) pulse(200, 1'b1, 1'b1);
        wait_rel(420);
        check({tag, "_idle_end"}, 32'(sched_busy), 32'd0);
        compare_stream(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Periodic position frames, position changed after every capture.
        select_mode = 1'b1;
        xpos = 10'd300;
        ypos = 10'd700;
        dir  = 2'd0;
        do_reset();
        push_pos(300, 700, 0);
        for (int k = 0; k < 3; k++) begin
            expect_start(k * (CSUM ? 4 : 3) + 1, PERIOD * (k + 1) + 2, $sformatf("period%0d", k));
            if (k < 2) begin
                randomize_pos();
                push_pos(xpos, ypos, dir);
            end
        end
        wait_rel(330);
        check("period_busy_mid", 32'(sched_busy), 32'd1);
        select_mode = 1'b0;
        wait_rel(600);
        check("period_busy_end", 32'(sched_busy), 32'd0);
        compare_stream("period");

        // Fire pulse in the same cycle as the timer wrap: event frame goes first.
        run_evt("fire_wrap", 1, PERIOD, 0, 0);

        // Fire and hit together, then a hit (twice, merged) during the event frame.
        run_evt("both_then_hit", 3, 30, 2, 2);

        // Transmitter that never raises busy: same byte resent every BUSY_TIMEOUT+1.
        select_mode = 1'b1;
        uart_dead   = 1'b1;
        do_reset();
        pulse(10, 1'b1, 1'b0);
        expect_start(1, 12, "resend0");
        expect_start(2, 12 + BUSY_TIMEOUT + 1, "resend1");
        for (int i = 0; i < obs_q.size(); i++)
            check($sformatf("resend_data%0d", i), 32'(obs_q[i]), 32'h81);
        // Reset lands exactly where the next resend would start.
        wait_rel(12 + 2 * (BUSY_TIMEOUT + 1) - 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_start", 32'(tx_start), 32'd0);
        check("abort_sched_busy", 32'(sched_busy), 32'd0);
        uart_dead = 1'b0;
        run_evt("after_abort", 0, 0, 0, 0);

        // Randomized mix of events, mid-frame pulses and position frames.
        for (int it = 0; it < 8; it++) begin
            int unsigned ev;
            ev = $urandom_range(0, 3);
            run_evt($sformatf("rnd%0d", it), ev, $urandom_range(5, 40),
                    (ev != 0) ? $urandom_range(0, 3) : 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
